// File: rtl/ttte_pkg.sv
// ttte_pkg: framing constants and FSM state type shared by the ttte serializer and receiver
package ttte_pkg;
  typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;
  localparam int TTTE_DATA_W = 32;
  localparam int TTTE_SYNC_W = 16;
  localparam logic [15:0] TTTE_SYNC_WORD = 16'hBEAF;
  localparam logic TTTE_IDLE_LVL = 1'b0;
  localparam logic TTTE_START_LVL = 1'b1;
endpackage

// File: rtl/ttte_sat_cnt.sv
// ttte_sat_cnt: saturating up-counter with asynchronous active-high clear
module ttte_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk or posedge clr)
    if (clr) cnt <= '0;
    else if (inc && !(&cnt)) cnt <= cnt + 1'b1;
endmodule

// File: rtl/ttte_des.sv
// ttte_des: serial frame receiver with sync-word check, error strobes and saturating counters
module ttte_des import ttte_pkg::*; #(
  parameter int DATA_W = TTTE_DATA_W,
  parameter int SYNC_W = TTTE_SYNC_W,
  parameter logic [SYNC_W-1:0] SYNC_WORD = TTTE_SYNC_WORD,
  parameter int CNT_W = 16
) (
  input  logic              t_clk,
  input  logic              rst,
  input  logic              ser_in,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              sync_err,
  output logic              frame_err,
  output logic              busy,
  output logic [CNT_W-1:0]  good_cnt,
  output logic [CNT_W-1:0]  err_cnt
);
  localparam int BW = $clog2(DATA_W + 1);
  state_t state;
  logic [BW-1:0] bit_cnt;
  logic [DATA_W-1:0] shift;
  logic stop_ok, sync_ok, good_inc, err_inc;
  always_comb begin
    stop_ok = ser_in == TTTE_IDLE_LVL;
    sync_ok = shift[SYNC_W-1:0] == SYNC_WORD;
    good_inc = state == STOP && stop_ok && sync_ok;
    err_inc = state == STOP && !(stop_ok && sync_ok);
  end
  always_ff @(posedge t_clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      bit_cnt <= '0;
      shift <= '0;
      rx_data <= '0;
      rx_valid <= 1'b0;
      sync_err <= 1'b0;
      frame_err <= 1'b0;
      busy <= 1'b0;
    end else begin
      rx_valid <= good_inc;
      frame_err <= state == STOP && !stop_ok;
      sync_err <= state == STOP && stop_ok && !sync_ok;
      if (good_inc) rx_data <= shift;
      case (state)
        IDLE: if (ser_in == TTTE_START_LVL) begin
          state <= DATA;
          bit_cnt <= '0;
          busy <= 1'b1;
        end
        DATA: begin
          shift <= {shift[DATA_W-2:0], ser_in};
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == BW'(DATA_W - 1)) state <= STOP;
        end
        STOP: begin
          state <= IDLE;
          busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  ttte_sat_cnt #(.W(CNT_W)) u_good (.clk(t_clk), .clr(rst), .inc(good_inc), .cnt(good_cnt));
  ttte_sat_cnt #(.W(CNT_W)) u_err (.clk(t_clk), .clr(rst), .inc(err_inc), .cnt(err_cnt));
endmodule

// File: tb/tb_ttte_des.sv
// tb_ttte_des: directed self-checking bench for ttte_des
module tb_ttte_des;
  logic t_clk = 0, rst = 1, ser_in = 0;
  logic [31:0] rx_data, rx_data2;
  logic rx_valid, sync_err, frame_err, busy;
  logic rx_valid2, sync_err2, frame_err2, busy2;
  logic [15:0] good_cnt, err_cnt;
  logic [1:0] good_cnt2, err_cnt2;
  int checks = 0, errors = 0, cyc = 0, t_start = 0;
  int n_valid = 0, n_sync = 0, n_frame = 0;

  ttte_des dut (.t_clk(t_clk), .rst(rst), .ser_in(ser_in), .rx_data(rx_data), .rx_valid(rx_valid),
    .sync_err(sync_err), .frame_err(frame_err), .busy(busy), .good_cnt(good_cnt), .err_cnt(err_cnt));
  ttte_des #(.CNT_W(2)) dut2 (.t_clk(t_clk), .rst(rst), .ser_in(ser_in), .rx_data(rx_data2),
    .rx_valid(rx_valid2), .sync_err(sync_err2), .frame_err(frame_err2), .busy(busy2),
    .good_cnt(good_cnt2), .err_cnt(err_cnt2));

  always #5 t_clk = ~t_clk;
  always @(posedge t_clk) cyc++;
  always @(negedge t_clk) begin
    n_valid += int'(rx_valid);
    n_sync += int'(sync_err);
    n_frame += int'(frame_err);
  end

  task automatic send_bit(input logic b);
    ser_in = b;
    @(posedge t_clk);
    #1;
  endtask

  task automatic idle(input int n);
    ser_in = 0;
    repeat (n) begin
      @(posedge t_clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [31:0] w, input logic stop);
    send_bit(1);
    t_start = cyc;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL busy_after_start got %b want 1", busy); end
    for (int i = 31; i >= 0; i--) send_bit(w[i]);
    send_bit(stop);
  endtask

  task automatic test_reset;
    bit quiet = 1;
    rst = 1;
    repeat (2) @(posedge t_clk);
    #1 rst = 0;
    checks++;
    if ({rx_data, rx_valid, sync_err, frame_err, busy, good_cnt, err_cnt} !== '0) begin
      errors++; $display("FAIL reset_state got %h/%b%b%b%b/%h/%h want all zero",
        rx_data, rx_valid, sync_err, frame_err, busy, good_cnt, err_cnt);
    end
    for (int i = 0; i < 50; i++) begin
      idle(1);
      if ({rx_data, rx_valid, sync_err, frame_err, busy, good_cnt, err_cnt} !== '0) quiet = 0;
    end
    checks++;
    if (!quiet) begin errors++; $display("FAIL idle_quiet got activity want none"); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] w [3] = '{32'hA201BEAF, 32'hA612BEAF, 32'hA623BEAF};
    int last = 0;
    int v0 = n_valid;
    for (int i = 0; i < 3; i++) begin
      send_frame(w[i], 0);
      checks += 3;
      if (rx_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d] got %b want 1", i, rx_valid); end
      if (rx_data !== w[i]) begin errors++; $display("FAIL b2b_data[%0d] got %h want %h", i, rx_data, w[i]); end
      if (i > 0 && cyc - last !== 34) begin errors++; $display("FAIL b2b_spacing[%0d] got %0d want 34", i, cyc - last); end
      else if (i == 0 && cyc - t_start !== 33) begin errors++; $display("FAIL b2b_latency got %0d want 33", cyc - t_start); end
      last = cyc;
    end
    idle(2);
    checks += 3;
    if (good_cnt !== 16'd3) begin errors++; $display("FAIL b2b_good_cnt got %0d want 3", good_cnt); end
    if (err_cnt !== 16'd0) begin errors++; $display("FAIL b2b_err_cnt got %0d want 0", err_cnt); end
    if (n_valid - v0 !== 3) begin errors++; $display("FAIL b2b_pulses got %0d want 3", n_valid - v0); end
  endtask

  task automatic test_sync_err;
    int s0 = n_sync;
    send_frame(32'hA201BEAE, 0);
    checks += 5;
    if (sync_err !== 1'b1) begin errors++; $display("FAIL sync_pulse got %b want 1", sync_err); end
    if (cyc - t_start !== 33) begin errors++; $display("FAIL sync_latency got %0d want 33", cyc - t_start); end
    if (rx_valid !== 1'b0) begin errors++; $display("FAIL sync_valid got %b want 0", rx_valid); end
    if (rx_data !== 32'hA623BEAF) begin errors++; $display("FAIL sync_hold got %h want a623beaf", rx_data); end
    if (err_cnt !== 16'd1) begin errors++; $display("FAIL sync_err_cnt got %0d want 1", err_cnt); end
    idle(3);
    checks++;
    if (n_sync - s0 !== 1) begin errors++; $display("FAIL sync_pulses got %0d want 1", n_sync - s0); end
  endtask

  task automatic test_frame_err;
    int s0 = n_sync, f0 = n_frame;
    send_frame(32'hA201BEAF, 1);
    checks += 3;
    if (frame_err !== 1'b1) begin errors++; $display("FAIL frame_pulse got %b want 1", frame_err); end
    if (rx_valid !== 1'b0) begin errors++; $display("FAIL frame_valid got %b want 0", rx_valid); end
    if (rx_data !== 32'hA623BEAF) begin errors++; $display("FAIL frame_hold got %h want a623beaf", rx_data); end
    idle(3);
    checks += 4;
    if (err_cnt !== 16'd2) begin errors++; $display("FAIL frame_err_cnt got %0d want 2", err_cnt); end
    if (busy !== 1'b0) begin errors++; $display("FAIL frame_no_restart got %b want 0", busy); end
    if (n_sync - s0 !== 0) begin errors++; $display("FAIL frame_no_sync got %0d want 0", n_sync - s0); end
    if (n_frame - f0 !== 1) begin errors++; $display("FAIL frame_pulses got %0d want 1", n_frame - f0); end
    send_frame(32'h0000BEAF, 0);
    checks += 3;
    if (rx_valid !== 1'b1) begin errors++; $display("FAIL after_frame_valid got %b want 1", rx_valid); end
    if (rx_data !== 32'h0000BEAF) begin errors++; $display("FAIL after_frame_data got %h want 0000beaf", rx_data); end
    if (good_cnt !== 16'd4) begin errors++; $display("FAIL after_frame_good got %0d want 4", good_cnt); end
    idle(2);
  endtask

  task automatic test_mid_reset;
    logic [31:0] w = 32'hA201BEAF;
    int v0, s0, f0;
    send_bit(1);
    for (int i = 31; i > 21; i--) send_bit(w[i]);
    rst = 1;
    @(posedge t_clk);
    #1 rst = 0;
    ser_in = 0;
    v0 = n_valid; s0 = n_sync; f0 = n_frame;
    checks++;
    if ({busy, good_cnt, err_cnt, rx_data} !== '0) begin
      errors++; $display("FAIL mid_reset_state got %b/%h/%h/%h want zero", busy, good_cnt, err_cnt, rx_data);
    end
    idle(40);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL mid_reset_idle got %b want 0", busy); end
    send_frame(32'hA612BEAF, 0);
    checks += 2;
    if (rx_valid !== 1'b1) begin errors++; $display("FAIL mid_reset_valid got %b want 1", rx_valid); end
    if (rx_data !== 32'hA612BEAF) begin errors++; $display("FAIL mid_reset_data got %h want a612beaf", rx_data); end
    idle(3);
    checks += 2;
    if (n_valid - v0 !== 1) begin errors++; $display("FAIL mid_reset_pulses got %0d want 1", n_valid - v0); end
    if (n_sync - s0 + n_frame - f0 !== 0 || err_cnt !== 16'd0) begin
      errors++; $display("FAIL mid_reset_errs got %0d/%0d want 0/0", n_sync - s0 + n_frame - f0, err_cnt);
    end
  endtask

  task automatic test_saturation;
    logic [1:0] exp2 [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    rst = 1;
    @(posedge t_clk);
    #1 rst = 0;
    for (int i = 0; i < 5; i++) begin
      send_frame(32'h1234BEAF + (i << 16), 0);
      idle(1);
      checks += 2;
      if (good_cnt2 !== exp2[i]) begin errors++; $display("FAIL sat_good2[%0d] got %0d want %0d", i, good_cnt2, exp2[i]); end
      if (good_cnt !== 16'(i + 1)) begin errors++; $display("FAIL sat_good16[%0d] got %0d want %0d", i, good_cnt, i + 1); end
    end
  endtask

  initial begin
    test_reset;
    test_back_to_back;
    test_sync_err;
    test_frame_err;
    test_mid_reset;
    test_saturation;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
